rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource between four agents. Each grant is reported both as a one-hot vector and as a 2-bit index, the same 4-to-2 encoding the encoder block produces. A grant is held while its owner keeps requesting. Under contention, a grant is pre-empted after a bounded number of cycles. The block sits between the requesting agents and the shared datapath, and its `gnt_id` drives the datapath's select input directly.

## Interface

**Parameters**
- `MAX_HOLD`, default 8: maximum number of consecutive grant cycles for one owner while another request is pending. A value of 0 means unlimited hold (no pre-emption).

**Ports**
- `clk`, input, 1: sole clock, rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 4: request vector; bit i high means agent i wants the resource.
- `gnt`, output, 4: registered one-hot grant, or 0 when no grant.
- `gnt_id`, output, 2: registered encoded index of `gnt`; 0 when `gnt_valid` is 0.
- `gnt_valid`, output, 1: registered; high whenever `gnt` is non-zero.
- `preempt`, output, 1: registered one-cycle pulse, coincident with the first cycle of a grant that was forced by the hold limit.

## Operation

**State**
- `state`: one of IDLE or GRANT.
- `ptr[1:0]`: search start pointer.
- `owner[1:0]`: current grant holder.
- `hold_cnt`: width `$clog2(MAX_HOLD+1)`, minimum 1 bit.

**Search(s)**
- Scans `req` at indices s, s+1, s+2, s+3, all mod 4.
- Returns the first set bit found.
- Excluding index k means skipping k in the scan.

**IDLE**
- If `req` != 0, go to GRANT with owner = search(`ptr`).
- `hold_cnt` is set to 0.
- Otherwise stay in IDLE with all outputs 0.

**GRANT, owner k**
- **Release:** `req[k]` = 0.
  - `ptr` becomes k+1 mod 4.
  - If any other `req` bit is set, owner becomes search(k+1) in the same edge, with no idle cycle.
  - Otherwise go to IDLE.
- **Pre-emption:** `MAX_HOLD` != 0, `req[k]` = 1, `hold_cnt` == `MAX_HOLD`-1, and another `req` bit is set.
  - Owner becomes search(k+1) excluding k.
  - `ptr` becomes k+1.
  - `preempt` = 1 for that one cycle.
- **Hold:** in all other cases the owner is unchanged.
  - `hold_cnt` increments.
  - `hold_cnt` saturates at `MAX_HOLD`-1.
- Every owner change (release hand-off or pre-emption) resets `hold_cnt` to 0.

**Outputs**
- `gnt` = one-hot of owner; `gnt_id` = owner; `gnt_valid` = 1 in GRANT.
- All three are 0 in IDLE.
- `gnt_id` always equals the 4-to-2 encoding of `gnt`.
- `gnt` never has more than one bit set.

**Boundary conditions**
- **Simultaneous release and pre-emption condition:** release wins, and `preempt` stays 0.
- **Single pending requester at the hold limit:** no pre-emption. The owner keeps the grant indefinitely and `hold_cnt` stays saturated.
- **Requests arriving for the owner that just released:** that agent is considered last, because the search starts at k+1.

**Reset**
- Takes precedence over everything.
- On the edge where `rst` = 1: state = IDLE, `ptr` = 0, `owner` = 0, `hold_cnt` = 0, `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `preempt` = 0.
- Reset during an active grant drops the grant on that edge.

## Timing

- **Grant latency:** 1 cycle. A `req` sampled at edge N appears on `gnt` after edge N.
- **Release latency:** 1 cycle. `req[k]` low at edge N means `gnt[k]` is low after edge N.
- **Hand-off:** zero-bubble. The new owner's grant starts in the same cycle the old grant ends.
- **Contended hold length:** with `MAX_HOLD` = M > 0 and continuous contention, each owner holds exactly M cycles.
- **Combinational paths:** none from inputs to outputs; all outputs are flops.

## Test plan

1. **Single request after reset.** `rst` high for 2 cycles, then `req` = 0001 → one cycle later `gnt` = 0001, `gnt_id` = 00, `gnt_valid` = 1, `preempt` = 0.
2. **Full contention.** `MAX_HOLD` = 4, `req` = 1111 held for 20 cycles → owner sequence 0, 1, 2, 3, 0, each for exactly 4 cycles. `preempt` pulses on the first cycle of owners 1, 2, 3 and on the return to 0; `gnt_id` tracks 00, 01, 10, 11, 00.
3. **Zero-bubble hand-off.** Owner 1 with `req` = 1010; drop `req[1]` → next cycle `gnt` = 1000 and `gnt_id` = 11, with `gnt_valid` continuously 1 and `preempt` = 0.
4. **Pointer fairness.** Owner 2 releases with `req` = 0000, then `req` = 0101 is applied two cycles later → `gnt` = 0001, because the search starts at index 3.
5. **Lone requester beyond the limit.** `MAX_HOLD` = 4, `req` = 0100 for 20 cycles → `gnt` = 0100 throughout and `preempt` is never asserted. When `req` = 0110 is then applied, `gnt` moves to 1000? No: the search from 3 wraps to 0, 1 → `gnt` = 0010 on the next edge with `preempt` = 1, because `hold_cnt` is already saturated.
6. **Reset mid-grant.** Owner 3 active with `req` = 1111; assert `rst` for 1 cycle → outputs all 0 after that edge. After release of `rst` with `req` = 1111, `gnt` = 0001 one cycle later, since `ptr` was reset to 0.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with
// bounded hold under contention and registered grant outputs.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam int CW =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HLIM =
    (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CW-1:0] CLIM = CW'(HLIM);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [1:0]    r_owner;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_gnt;
  logic [1:0]    r_gnt_id;
  logic          r_gnt_valid;
  logic          r_preempt;

  state_t        w_state_nx;
  logic [1:0]    w_ptr_nx;
  logic [1:0]    w_owner_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_pre_nx;
  logic [3:0]    w_gnt_nx;
  logic [1:0]    w_id_nx;
  logic          w_valid_nx;
  logic [3:0]    w_k_oh;
  logic [1:0]    w_nxt;
  logic          w_others;

  // First set bit of r scanning from s upward, mod 4.
  function automatic logic [1:0] f_search(
    input logic [3:0] r,
    input logic [1:0] s
  );
    logic [1:0] idx;
    logic [1:0] res;
    logic       hit;
    res = s;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = s + 2'(i);
      if (!hit && r[idx]) begin
        res = idx;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_k_oh   = 4'b0001 << r_owner;
  assign w_nxt    = r_owner + 2'd1;
  assign w_others = |(req & ~w_k_oh);

  // State register: FSM state, bookkeeping and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_owner     <= 2'd0;
      r_cnt       <= '0;
      r_gnt       <= 4'd0;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_owner     <= w_owner_nx;
      r_cnt       <= w_cnt_nx;
      r_gnt       <= w_gnt_nx;
      r_gnt_id    <= w_id_nx;
      r_gnt_valid <= w_valid_nx;
      r_preempt   <= w_pre_nx;
    end
  end

  // Next state: grant, release hand-off, pre-emption, hold.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_pre_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (|req) begin
          w_state_nx = S_GRANT;
          w_owner_nx = f_search(req, r_ptr);
        end
      end
      S_GRANT: begin
        if (!req[r_owner]) begin
          w_ptr_nx = w_nxt;
          w_cnt_nx = '0;
          if (w_others)
            w_owner_nx = f_search(req, w_nxt);
          else
            w_state_nx = S_IDLE;
        end else if (HOLD_EN && r_cnt == CLIM
                     && w_others) begin
          w_owner_nx =
            f_search(req & ~w_k_oh, w_nxt);
          w_ptr_nx = w_nxt;
          w_cnt_nx = '0;
          w_pre_nx = 1'b1;
        end else if (HOLD_EN && r_cnt != CLIM) begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    w_gnt_nx   = 4'd0;
    w_id_nx    = 2'd0;
    w_valid_nx = 1'b0;
    if (w_state_nx == S_GRANT) begin
      w_gnt_nx   = 4'b0001 << w_owner_nx;
      w_id_nx    = w_owner_nx;
      w_valid_nx = 1'b1;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed and random checks of rr_arbiter4
// against a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  bit m_busy = 0;
  int m_ptr  = 0;
  int m_own  = 0;
  int m_cnt  = 0;
  bit m_pre  = 0;

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  function automatic int first(
    input logic [3:0] r,
    input int s
  );
    for (int j = 0; j < 4; j++)
      if (r[(s + j) % 4]) return (s + j) % 4;
    return 0;
  endfunction

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] r, input bit rs);
    logic [3:0] oth;
    m_pre = 0;
    if (rs) begin
      m_busy = 0; m_ptr = 0; m_own = 0; m_cnt = 0;
    end else if (!m_busy) begin
      m_cnt = 0;
      if (r != 0) begin
        m_busy = 1;
        m_own  = first(r, m_ptr);
      end
    end else begin
      oth = r & ~(4'b0001 << m_own);
      if (!r[m_own]) begin
        m_ptr = (m_own + 1) % 4;
        m_cnt = 0;
        if (oth != 0) m_own = first(r, m_ptr);
        else m_busy = 0;
      end else if (oth != 0 && m_cnt == MH - 1) begin
        m_ptr = (m_own + 1) % 4;
        m_own = first(oth, m_ptr);
        m_cnt = 0;
        m_pre = 1;
      end else if (m_cnt < MH - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input bit rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model(r, rs);
    #1;
    chk("m_gnt", {4'd0, gnt},
        m_busy ? (8'd1 << m_own) : 8'd0);
    chk("m_id", {6'd0, gnt_id},
        m_busy ? 8'(m_own) : 8'd0);
    chk("m_valid", {7'd0, gnt_valid}, {7'd0, m_busy});
    chk("m_pre", {7'd0, preempt}, {7'd0, m_pre});
  endtask

  initial begin
    // 1: single request after reset
    cyc(4'b0000, 1);
    cyc(4'b0000, 1);
    chk("rst_gnt", {4'd0, gnt}, 8'h00);
    chk("rst_valid", {7'd0, gnt_valid}, 8'h00);
    cyc(4'b0001, 0);
    chk("t1_gnt", {4'd0, gnt}, 8'h01);
    chk("t1_id", {6'd0, gnt_id}, 8'h00);
    chk("t1_valid", {7'd0, gnt_valid}, 8'h01);
    chk("t1_pre", {7'd0, preempt}, 8'h00);

    // 2: full contention, 4-cycle slots
    cyc(4'b0000, 1);
    for (int i = 1; i <= 20; i++) begin
      cyc(4'b1111, 0);
      chk("t2_id", {6'd0, gnt_id},
          8'(((i - 1) / 4) % 4));
      chk("t2_pre", {7'd0, preempt},
          (i > 1 && (i - 1) % 4 == 0) ? 8'h01 : 8'h00);
    end

    // 3: zero-bubble hand-off
    cyc(4'b0000, 1);
    cyc(4'b0010, 0);
    cyc(4'b1010, 0);
    chk("t3_pre_gnt", {4'd0, gnt}, 8'h02);
    cyc(4'b1000, 0);
    chk("t3_gnt", {4'd0, gnt}, 8'h08);
    chk("t3_id", {6'd0, gnt_id}, 8'h03);
    chk("t3_valid", {7'd0, gnt_valid}, 8'h01);
    chk("t3_pre", {7'd0, preempt}, 8'h00);

    // 4: pointer fairness after release
    cyc(4'b0000, 1);
    cyc(4'b0100, 0);
    cyc(4'b0000, 0);
    chk("t4_idle", {7'd0, gnt_valid}, 8'h00);
    cyc(4'b0000, 0);
    cyc(4'b0101, 0);
    chk("t4_gnt", {4'd0, gnt}, 8'h01);

    // 5: lone requester beyond the limit
    cyc(4'b0000, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0100, 0);
      chk("t5_gnt", {4'd0, gnt}, 8'h04);
      chk("t5_pre", {7'd0, preempt}, 8'h00);
    end
    cyc(4'b0110, 0);
    chk("t5_new_gnt", {4'd0, gnt}, 8'h02);
    chk("t5_new_pre", {7'd0, preempt}, 8'h01);

    // 6: reset mid-grant
    cyc(4'b0000, 1);
    cyc(4'b1000, 0);
    cyc(4'b1111, 0);
    chk("t6_own3", {6'd0, gnt_id}, 8'h03);
    cyc(4'b1111, 1);
    chk("t6_rst_gnt", {4'd0, gnt}, 8'h00);
    chk("t6_rst_id", {6'd0, gnt_id}, 8'h00);
    chk("t6_rst_valid", {7'd0, gnt_valid}, 8'h00);
    chk("t6_rst_pre", {7'd0, preempt}, 8'h00);
    cyc(4'b1111, 0);
    chk("t6_gnt", {4'd0, gnt}, 8'h01);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(4'($urandom), ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
